// File: rtl/div_iter_if.sv
// div_iter_if: EX-stage divider request/result bundle.
// master = pipeline side, slave = divider side.
interface div_iter_if #(
    parameter int WIDTH = 32
);
    logic             div_startE;
    logic             div_signedE;
    logic [WIDTH-1:0] src_aE;
    logic [WIDTH-1:0] src_bE;
    logic             stall_ext;
    logic             annulE;
    logic             stall_divE;
    logic             div_readyE;
    logic [WIDTH-1:0] quotE;
    logic [WIDTH-1:0] remE;

    modport master (
        output div_startE,
        output div_signedE,
        output src_aE,
        output src_bE,
        output stall_ext,
        output annulE,
        input  stall_divE,
        input  div_readyE,
        input  quotE,
        input  remE
    );

    modport slave (
        input  div_startE,
        input  div_signedE,
        input  src_aE,
        input  src_bE,
        input  stall_ext,
        input  annulE,
        output stall_divE,
        output div_readyE,
        output quotE,
        output remE
    );
endinterface

// File: rtl/div_iter.sv
// div_iter: iterative radix-2 restoring divider, DIV/DIVU.
// One quotient bit per cycle; sign fixed up on entry to DONE.
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst,
    div_iter_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH:0]   remReg;
    logic [WIDTH-1:0] quotReg;
    logic             signQ;
    logic             signR;
    logic [WIDTH-1:0] quotOut;
    logic [WIDTH-1:0] remOut;
    logic             readyReg;

    logic [WIDTH-1:0] absA;
    logic [WIDTH-1:0] absB;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   nextRem;
    logic [WIDTH-1:0] nextQuot;
    logic [WIDTH-1:0] quotFix;
    logic [WIDTH-1:0] remFix;
    logic             lastIter;
    logic             startOk;

    // Operand magnitudes for the IDLE->BUSY capture.
    always_comb begin
        absA = bus.src_aE;
        absB = bus.src_bE;
        if (bus.div_signedE && bus.src_aE[WIDTH-1]) begin
            absA = -bus.src_aE;
        end
        if (bus.div_signedE && bus.src_bE[WIDTH-1]) begin
            absB = -bus.src_bE;
        end
    end

    // One restoring step: shift, trial subtract, keep or restore.
    always_comb begin
        shifted = {remReg[WIDTH-1:0], quotReg[WIDTH-1]};
        trial   = shifted - {1'b0, divisor};
        if (trial[WIDTH]) begin
            nextRem  = shifted;
            nextQuot = {quotReg[WIDTH-2:0], 1'b0};
        end else begin
            nextRem  = trial;
            nextQuot = {quotReg[WIDTH-2:0], 1'b1};
        end
        quotFix = signQ ? -nextQuot : nextQuot;
        remFix  = signR ? -nextRem[WIDTH-1:0]
                        : nextRem[WIDTH-1:0];
    end

    assign lastIter = (count == CW'(WIDTH - 1));
    assign startOk  = bus.div_startE & ~bus.annulE;

    // Stall must rise in the issue cycle and drop at once on annul.
    always_comb begin
        unique case (state)
            IDLE:    bus.stall_divE = startOk;
            BUSY:    bus.stall_divE = ~bus.annulE;
            default: bus.stall_divE = 1'b0;
        endcase
    end

    assign bus.div_readyE = readyReg & ~bus.annulE;
    assign bus.quotE      = quotOut;
    assign bus.remE       = remOut;

    // Control FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            divisor  <= '0;
            remReg   <= '0;
            quotReg  <= '0;
            signQ    <= 1'b0;
            signR    <= 1'b0;
            quotOut  <= '0;
            remOut   <= '0;
            readyReg <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    readyReg <= 1'b0;
                    if (startOk) begin
                        divisor <= absB;
                        quotReg <= absA;
                        remReg  <= '0;
                        count   <= '0;
                        signQ   <= bus.div_signedE &
                                   (bus.src_aE[WIDTH-1] ^
                                    bus.src_bE[WIDTH-1]);
                        signR   <= bus.div_signedE &
                                   bus.src_aE[WIDTH-1];
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (bus.annulE) begin
                        state <= IDLE;
                    end else begin
                        remReg  <= nextRem;
                        quotReg <= nextQuot;
                        count   <= count + CW'(1);
                        if (lastIter) begin
                            quotOut  <= quotFix;
                            remOut   <= remFix;
                            readyReg <= 1'b1;
                            state    <= DONE;
                        end
                    end
                end
                DONE: begin
                    // A start seen here is the finishing instruction.
                    if (bus.annulE || !bus.stall_ext) begin
                        readyReg <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    readyReg <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: directed scoreboard bench for div_iter.
// Expected results are queued at issue and popped at div_readyE.
module tb_div_iter;
    localparam int W = 32;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
    } res_t;

    logic clk;
    logic rst;
    int   nAsserts;
    int   nFail;
    res_t sb[$];
    logic [W-1:0] lastQ;
    logic [W-1:0] lastR;

    div_iter_if #(.WIDTH(W)) bus ();

    div_iter #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag,
                         input logic [W-1:0] obs,
                         input logic [W-1:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %h expected %h",
                   tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic runDiv(input string tag,
                          input logic [W-1:0] a,
                          input logic [W-1:0] b,
                          input logic sgn,
                          input logic [W-1:0] eq,
                          input logic [W-1:0] er,
                          input int hold);
        int   cycles;
        res_t exp;
        res_t got;
        exp.q = eq;
        exp.r = er;
        sb.push_back(exp);
        bus.div_startE  = 1'b1;
        bus.div_signedE = sgn;
        bus.src_aE      = a;
        bus.src_bE      = b;
        #1;
        cycles = 0;
        while (bus.stall_divE && cycles < 100) begin
            cycles++;
            step();
            if (cycles == 3) begin
                bus.src_aE = ~a;
                bus.src_bE = 32'h3;
            end
        end
        check({tag, " stall cycles"}, W'(cycles), W'(33));
        check({tag, " ready"}, W'(bus.div_readyE), W'(1));
        got.q = 'x;
        got.r = 'x;
        if (sb.size() > 0) got = sb.pop_front();
        check({tag, " quot"}, bus.quotE, got.q);
        check({tag, " rem"}, bus.remE, got.r);
        if (hold > 0) begin
            bus.stall_ext = 1'b1;
            for (int i = 0; i < hold; i++) begin
                step();
                check({tag, " hold ready"},
                      W'(bus.div_readyE), W'(1));
                check({tag, " hold stall"},
                      W'(bus.stall_divE), W'(0));
                check({tag, " hold quot"}, bus.quotE, got.q);
                check({tag, " hold rem"}, bus.remE, got.r);
            end
            bus.stall_ext = 1'b0;
        end
        bus.div_startE = 1'b0;
        step();
        check({tag, " idle ready"}, W'(bus.div_readyE), W'(0));
        check({tag, " idle stall"}, W'(bus.stall_divE), W'(0));
        lastQ = got.q;
        lastR = got.r;
    endtask

    initial begin
        logic [W-1:0]        ua;
        logic [W-1:0]        ub;
        logic signed [W-1:0] sa;
        logic signed [W-1:0] sb2;
        logic [W-1:0]        eq;
        logic [W-1:0]        er;

        nAsserts        = 0;
        nFail           = 0;
        rst             = 1'b1;
        bus.div_startE  = 1'b0;
        bus.div_signedE = 1'b0;
        bus.src_aE      = '0;
        bus.src_bE      = '0;
        bus.stall_ext   = 1'b0;
        bus.annulE      = 1'b0;
        repeat (3) step();
        check("reset stall", W'(bus.stall_divE), W'(0));
        check("reset ready", W'(bus.div_readyE), W'(0));
        check("reset quot", bus.quotE, W'(0));
        check("reset rem", bus.remE, W'(0));
        rst = 1'b0;
        step();

        runDiv("u100/7", 32'd100, 32'd7, 1'b0,
               32'd14, 32'd2, 0);
        runDiv("s-7/2", 32'hFFFFFFF9, 32'h2, 1'b1,
               32'hFFFFFFFD, 32'hFFFFFFFF, 0);
        runDiv("s7/-2", 32'h7, 32'hFFFFFFFE, 1'b1,
               32'hFFFFFFFD, 32'h1, 0);
        runDiv("uMax/2", 32'hFFFFFFFF, 32'h2, 1'b0,
               32'h7FFFFFFF, 32'h1, 0);
        runDiv("sOvf", 32'h80000000, 32'hFFFFFFFF, 1'b1,
               32'h80000000, 32'h0, 0);
        runDiv("u5/0", 32'd5, 32'd0, 1'b0,
               32'hFFFFFFFF, 32'd5, 0);
        runDiv("s-9/0", 32'hFFFFFFF7, 32'd0, 1'b1,
               32'h00000001, 32'hFFFFFFF7, 0);
        runDiv("hold1000/3", 32'd1000, 32'd3, 1'b0,
               32'd333, 32'd1, 4);

        // Annul at BUSY iteration 10.
        bus.div_startE  = 1'b1;
        bus.div_signedE = 1'b0;
        bus.src_aE      = 32'd50;
        bus.src_bE      = 32'd6;
        repeat (11) step();
        check("annul pre stall", W'(bus.stall_divE), W'(1));
        bus.annulE     = 1'b1;
        bus.div_startE = 1'b0;
        #1;
        check("annul comb stall", W'(bus.stall_divE), W'(0));
        step();
        bus.annulE = 1'b0;
        #1;
        check("annul stall", W'(bus.stall_divE), W'(0));
        check("annul ready", W'(bus.div_readyE), W'(0));
        check("annul quot", bus.quotE, lastQ);
        check("annul rem", bus.remE, lastR);
        repeat (3) step();
        check("annul idle ready", W'(bus.div_readyE), W'(0));

        runDiv("u123456789/1000", 32'd123456789, 32'd1000,
               1'b0, 32'd123456, 32'd789, 0);

        for (int i = 0; i < 3; i++) begin
            ua = $urandom;
            ub = $urandom_range(1, 100000);
            eq = ua / ub;
            er = ua % ub;
            runDiv("urand", ua, ub, 1'b0, eq, er, 0);
        end
        for (int i = 0; i < 3; i++) begin
            sa  = $signed($urandom);
            sb2 = $signed(W'($urandom_range(1, 70000)));
            if (i != 1) sb2 = -sb2;
            eq = sa / sb2;
            er = sa % sb2;
            runDiv("srand", sa, sb2, 1'b1, eq, er, 0);
        end

        // Reset mid-BUSY.
        bus.div_startE  = 1'b1;
        bus.div_signedE = 1'b0;
        bus.src_aE      = 32'd77;
        bus.src_bE      = 32'd5;
        repeat (15) step();
        rst            = 1'b1;
        bus.div_startE = 1'b0;
        @(posedge clk);
        #1;
        check("rst stall", W'(bus.stall_divE), W'(0));
        check("rst ready", W'(bus.div_readyE), W'(0));
        check("rst quot", bus.quotE, W'(0));
        check("rst rem", bus.remE, W'(0));
        step();
        rst = 1'b0;
        step();

        runDiv("post-rst 9/4", 32'd9, 32'd4, 1'b0,
               32'd2, 32'd1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nAsserts, nFail);
        $finish;
    end
endmodule

// File: doc/div_iter.md
Name: div_iter

Overview:
Iterative radix-2 restoring divider for the EX stage of the 5-stage MIPS pipeline. It executes DIV/DIVU and produces quotient (LO) and remainder (HI). It drives stall_divE into the hazard unit, which freezes F/D/E while a division is in flight. Results are held until the EX stage is allowed to advance.

Parameters:
WIDTH, 32, operand width; the iteration count equals WIDTH.

Ports:
clk  input  1  system clock
rst  input  1  reset, synchronous, active-high
div_startE  input  1  EX-stage instruction is DIV/DIVU (level; held high by the pipeline while stalled)
div_signedE  input  1  1 = DIV (two's complement), 0 = DIVU
src_aE  input  WIDTH  dividend (rs)
src_bE  input  WIDTH  divisor (rt)
stall_ext  input  1  other stall holding EX (i_stall | d_stall); keeps a finished result held
annulE  input  1  cancel any in-flight division (exception/flush)
stall_divE  output  1  to hazard unit; high while a division is pending or busy
div_readyE  output  1  result valid this cycle
quotE  output  WIDTH  quotient (to LO)
remE  output  WIDTH  remainder (to HI)

Behaviour:
- Reset: state=IDLE, counter=0, internal regs=0. Outputs stall_divE=0, div_readyE=0, quotE=0, remE=0.
- States: IDLE, BUSY, DONE.
- IDLE:
  - If div_startE & ~annulE: latch |a|, |b| (magnitudes when div_signedE, else raw), sign_q = a[W-1]^b[W-1], sign_r = a[W-1] (both signed only). Clear partial remainder and counter; go BUSY.
  - stall_divE = div_startE & ~annulE, combinational in IDLE, so the same cycle stalls.
- BUSY:
  - Each cycle shift {rem,quot} left 1; trial-subtract divisor from the (WIDTH+1)-bit remainder; restore if negative, else set the quotient LSB.
  - Counter increments 0..WIDTH-1. After the WIDTH-th iteration, go DONE. stall_divE=1 throughout.
- DONE:
  - quotE/remE = sign-corrected registered results: negate quotient if sign_q, negate remainder if sign_r.
  - div_readyE=1, stall_divE=0.
  - Stay in DONE while stall_ext=1. Otherwise go IDLE next cycle.
  - A div_startE seen in DONE belongs to the finishing instruction and does not restart.
- Latency: start in cycle 0 → stall_divE high cycles 0..WIDTH (WIDTH+1 cycles) → DONE in cycle WIDTH+1 with results valid.
- quotE/remE hold their last value in IDLE/BUSY; they update only on entering DONE.
- Divide by zero (b=0): no trap. quotE = all ones (unsigned) or sign-adjusted all ones (signed). remE = src_aE. Latency unchanged.
- Signed overflow (-2^(W-1) / -1): quotE = 0x80000000, remE = 0. This arithmetic falls out naturally; no special casing.
- Remainder sign follows the dividend; the quotient truncates toward zero (MIPS semantics).
- annulE in any state:
  - Go IDLE next cycle and drop stall_divE combinationally in that cycle.
  - Leave quotE/remE unchanged; div_readyE=0.
- rst mid-operation: return to IDLE on the next edge; all outputs take their reset values.
- Operands are sampled only in the IDLE→BUSY cycle. Later changes on src_aE/src_bE are ignored.

Test Plan:
- Unsigned 100/7 (div_signedE=0) → stall_divE high for 33 cycles; cycle 33 div_readyE=1, quotE=14, remE=2. Next cycle IDLE, stall_divE=0.
- Signed -7/2 (0xFFFFFFF9, 0x2) → quotE=0xFFFFFFFD, remE=0xFFFFFFFF. Also 7/-2 → quotE=0xFFFFFFFD, remE=1.
- Unsigned 0xFFFFFFFF/2 → quotE=0x7FFFFFFF, remE=1. Signed 0x80000000/0xFFFFFFFF → quotE=0x80000000, remE=0.
- Divide by zero, unsigned 5/0 → quotE=0xFFFFFFFF, remE=5 after the full latency, no hang.
- Hold and back-to-back:
  - stall_ext=1 for 4 cycles during DONE → div_readyE stays 1 with stable results and no restart.
  - A second div_startE issued after DONE→IDLE → starts a new 33-cycle stall.
- Cancel:
  - annulE at BUSY iteration 10 → next cycle IDLE, stall_divE=0, quotE/remE unchanged.
  - rst asserted mid-BUSY → all outputs 0 on the next edge.
